reg_sweep_arbiter: RTL
======================

Name: reg_sweep_arbiter

Overview:
Shares the single register-file write port among NREQ requesters. Each requester asks for a "sweep": a run of consecutive register writes from a start register, going up or down. The block picks one requester per sweep using round-robin priority. It then steps the register number one write per cycle and sends a one-cycle done pulse back to the owner. It sits between the sweep-requesting control units and the register file's write-enable/write-number inputs.

Parameters:
NREQ, 4, number of requesters (2..8)
LEN_W, 3, width of each length field; a sweep writes len+1 registers (1..2^LEN_W)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
req  in  NREQ  bit k = requester k wants a sweep; level-sensitive
dir  in  NREQ  bit k: 1 = count up, 0 = count down
start_reg  in  5*NREQ  bits [5k+4:5k] = first register of requester k
len  in  LEN_W*NREQ  bits [LEN_W*k+LEN_W-1:LEN_W*k] = write count minus 1
grant  out  NREQ  one-hot owner, held during RUN and DONE
done  out  NREQ  one-hot, one-cycle pulse to owner at end of sweep
busy  out  1  high in RUN and DONE
wr_en  out  1  register-file write enable
wr_regnum  out  5  register-file write address

Behaviour:
- Reset values: state=IDLE, grant=0, done=0, busy=0, wr_en=0, wr_regnum=0, rr_ptr=0.
- Reset is checked first in every state, so a reset mid-sweep wins over everything else.
- Reset mid-sweep: next cycle is IDLE with all outputs at reset values. No done pulse is issued, the sweep is dropped, and rr_ptr returns to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set: pick winner w = first set req bit searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Latch dir[w], start_reg[w] and len[w] into internal registers.
  - Load remaining-count = len[w].
  - Next cycle: state=RUN, grant=onehot(w), wr_en=1, wr_regnum=start_reg[w].
  - Latency from req sampled to first write is 1 cycle.
- RUN: one write per cycle.
  - If remaining-count=0: next state=DONE.
  - Else: decrement remaining-count, and wr_regnum steps +1 (dir=1) or -1 (dir=0) modulo 32.
  - Wrap-around: 31+1 -> 0, 0-1 -> 31.
  - Total writes in a sweep = len+1 consecutive cycles.
- DONE: wr_en=0, done[w]=1 for exactly this cycle, grant held. Set rr_ptr=(w+1) mod NREQ. Next state=IDLE.
- wr_regnum keeps its last value outside RUN; it is don't-care whenever wr_en=0.
- Inputs are latched once per sweep. Changes to req/dir/start_reg/len of any requester during RUN or DONE are ignored, including the owner dropping req; the sweep always completes and done is still pulsed.
- Request rules:
  - A requester holds req until it sees its done pulse, and must deassert it in the cycle after done to avoid being counted as a new request.
  - If req is still high in IDLE, it is treated as a new request, still subject to round-robin priority.
- Simultaneous requests: resolved only by rr_ptr, and no requester can win twice while another is waiting.
- Minimum sweep-to-sweep gap: DONE + IDLE = 2 cycles with wr_en=0.
- At most one of grant/done bits is set at any time.

Optional Feature:
Macro: REG_SWEEP_SKIP_ZERO_EN
- Defined: in RUN, wr_en=0 whenever wr_regnum=0. That write slot is still used up (count decrements, timing unchanged), which protects hardwired register $0.
- Not defined: register 0 is written like any other register.

Test Plan:
- Reset, then req=0010, dir[1]=1, start_reg[1]=8, len[1]=3: next 4 cycles wr_en=1 with wr_regnum=8,9,10,11 and grant=0010; next cycle done=0010, wr_en=0; then IDLE with busy=0.
- Down wrap: req=0001, dir[0]=0, start_reg[0]=1, len[0]=2: wr_regnum=1,0,31 over 3 cycles, then done=0001.
- Arbitration: after reset, req=0101 held and each owner drops its bit after its done, then raises it again: grants come in order 0001, 0100, 0001, 0100. With req=1111 held by all, grant order is 0001, 0010, 0100, 1000, 0001.
- Reset in the 2nd RUN cycle of a len=5 sweep from requester 2: next cycle wr_en=0, grant=0, busy=0, and no done pulse. A following req=1100 is granted to requester 2, since rr_ptr=0.
- Owner drops req in the 1st RUN cycle (len=2) while its start_reg changes: all 3 writes still use the latched start value, and done is pulsed.
- Up wrap at 30, len=3: writes go to 30, 31, 0, 1. With REG_SWEEP_SKIP_ZERO_EN defined, wr_en is 1,1,0,1; without it, wr_en is 1,1,1,1. Done is pulsed 4 cycles after the first write in both cases.

Source files
------------

// File: rtl/reg_sweep_arbiter.sv
// Round-robin arbiter that lends the register-file write port to one requester per sweep.
// Optional macro REG_SWEEP_SKIP_ZERO_EN suppresses writes to register 0 while keeping sweep timing.
module reg_sweep_arbiter #(
   parameter int NREQ  = 4,
   parameter int LEN_W = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         dir,
   input  logic [5*NREQ-1:0]       start_reg,
   input  logic [LEN_W*NREQ-1:0]   len,
   output logic [NREQ-1:0]         grant,
   output logic [NREQ-1:0]         done,
   output logic                    busy,
   output logic                    wr_en,
   output logic [4:0]              wr_regnum
);

   localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [PTR_W-1:0]   r_rr_ptr;
   logic [PTR_W-1:0]   r_owner;
   logic               r_dir;
   logic [LEN_W-1:0]   r_rem;
   logic [4:0]         r_regnum;
   logic [PTR_W-1:0]   w_win;
   logic               w_found;
   logic [NREQ-1:0]    w_owner_oh;

   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a, input int b);
      int s;
      s = int'(a) + b;
      if (s >= NREQ) s = s - NREQ;
      return PTR_W'(s);
   endfunction

   // First requesting index at or after the round-robin pointer.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!w_found && req[wrap_add(r_rr_ptr, i)]) begin
            w_found = 1'b1;
            w_win   = wrap_add(r_rr_ptr, i);
         end
      end
   end

   assign w_owner_oh = NREQ'(1) << r_owner;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // NOTE: every output gets a default first, so no path through the case leaves one unassigned (no latch).
   always_comb begin
      w_next = r_state;
      grant  = '0;
      done   = '0;
      busy   = 1'b0;
      wr_en  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) w_next = S_RUN;
         end
         S_RUN: begin
            busy  = 1'b1;
            grant = w_owner_oh;
`ifdef REG_SWEEP_SKIP_ZERO_EN
            wr_en = (r_regnum != 5'd0);
`else
            wr_en = 1'b1;
`endif
            if (r_rem == '0) w_next = S_DONE;
         end
         S_DONE: begin
            busy   = 1'b1;
            grant  = w_owner_oh;
            done   = w_owner_oh;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign wr_regnum = r_regnum;

   // Sweep parameters are captured once on the grant edge; later input changes are ignored.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rr_ptr <= '0;
         r_owner  <= '0;
         r_dir    <= 1'b0;
         r_rem    <= '0;
         r_regnum <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_owner  <= w_win;
                  r_dir    <= dir[w_win];
                  r_rem    <= len[int'(w_win)*LEN_W +: LEN_W];
                  r_regnum <= start_reg[int'(w_win)*5 +: 5];
               end
            end
            S_RUN: begin
               if (r_rem != '0) begin
                  r_rem    <= r_rem - 1'b1;
                  r_regnum <= r_dir ? r_regnum + 5'd1 : r_regnum - 5'd1;
               end
            end
            S_DONE: begin
               r_rr_ptr <= wrap_add(r_owner, 1);
            end
            default: ;
         endcase
      end
   end

endmodule
